// File: rtl/router_pkg.sv
// ============================================================================
// router_pkg : router-wide widths, port ids and flit type
// Revision   : 1.0
// ============================================================================
`default_nettype none

package router_pkg;

  localparam int DATA_W    = 64;
  localparam int NUM_PORTS = 5;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  typedef logic [DATA_W-1:0] flit_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational one-hot round-robin pick starting at ptr
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  int   idx;
  logic found;

  // Scan NUM_REQ slots starting at ptr, wrapping past the top index.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/router_output_arbiter.sv
// ============================================================================
// router_output_arbiter : per-output round-robin arbiter with two one-flit VCs
// Revision              : 1.0
// ============================================================================
`default_nettype none

module router_output_arbiter #(
  parameter int NUM_REQ = router_pkg::NUM_PORTS,
  parameter int DATA_W  = router_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      polarity,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      out_ready,
  output logic                      out_send,
  output logic [DATA_W-1:0]         out_data,
  output logic [1:0]                vc_full
);

  import router_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]        vc_valid;
  logic [DATA_W-1:0] vc_data [2];
  logic [PTR_W-1:0]  rr_ptr  [2];

  logic              fill_vc;
  logic              drain_vc;
  logic [NUM_REQ-1:0] arb_grant;
  logic [PTR_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;

  assign fill_vc  = polarity;
  assign drain_vc = ~polarity;
  assign vc_full  = vc_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr[fill_vc]),
    .grant (arb_grant)
  );

  // A full fill VC blocks all grants; reset masks grant asynchronously.
  always_comb begin
    grant = arb_grant;
    if (reset || vc_valid[fill_vc]) grant = '0;
  end

  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx  = PTR_W'(i);
        grant_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc_valid   <= 2'b00;
      vc_data[0] <= '0;
      vc_data[1] <= '0;
      rr_ptr[0]  <= '0;
      rr_ptr[1]  <= '0;
      out_send   <= 1'b0;
      out_data   <= '0;
    end else begin
      if (|grant) begin
        vc_data[fill_vc]  <= grant_data;
        vc_valid[fill_vc] <= 1'b1;
        rr_ptr[fill_vc]   <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
      // Fill and drain always address opposite VCs, so both may act this edge.
      if (vc_valid[drain_vc] && out_ready) begin
        out_data           <= vc_data[drain_vc];
        out_send           <= 1'b1;
        vc_valid[drain_vc] <= 1'b0;
      end else begin
        out_data <= '0;
        out_send <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_router_output_arbiter.sv
// ============================================================================
// tb_router_output_arbiter : vector table, corner sequences and random traffic
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module tb_router_output_arbiter;

  import router_pkg::*;

  localparam int N = NUM_PORTS;
  localparam int W = DATA_W;

  logic           clk       = 1'b0;
  logic           reset     = 1'b1;
  logic           polarity  = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   req       = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   grant;
  logic           out_send;
  logic [W-1:0]   out_data;
  logic [1:0]     vc_full;

  router_output_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .out_ready (out_ready),
    .out_send  (out_send),
    .out_data  (out_data),
    .vc_full   (vc_full)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference state: two single-slot buffers and a next-port pointer per VC.
  bit           m_valid [2];
  logic [W-1:0] m_data  [2];
  int           m_ptr   [2];
  logic         e_send;
  logic [W-1:0] e_data;

  typedef struct {
    bit           pol;
    logic [N-1:0] rq;
    logic [W-1:0] data;
    bit           rdy;
    logic [N-1:0] g;
    logic [1:0]   full;
    bit           send;
    logic [W-1:0] dout;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_valid[v] = 1'b0;
      m_data[v]  = '0;
      m_ptr[v]   = 0;
    end
    e_send = 1'b0;
    e_data = '0;
  endtask

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    int p;
    g = '0;
    p = polarity ? 1 : 0;
    if (reset || m_valid[p]) return g;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr[p] + k) % N;
      if (req[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_edge(input logic [N-1:0] g);
    int p;
    int q;
    p = polarity ? 1 : 0;
    q = 1 - p;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        m_data[p]  = req_data[i*W +: W];
        m_valid[p] = 1'b1;
        m_ptr[p]   = (i + 1) % N;
      end
    end
    e_send = 1'b0;
    e_data = '0;
    if (m_valid[q] && out_ready) begin
      e_send     = 1'b1;
      e_data     = m_data[q];
      m_valid[q] = 1'b0;
    end
  endtask

  // Inputs are set before the call; grant checked mid-cycle, registers 1ns after the edge.
  task automatic cycle(input string tag);
    logic [N-1:0] g;
    #1;
    g = model_grant();
    chk({tag, ".grant"}, W'(grant), W'(g));
    model_edge(g);
    @(posedge clk);
    #1;
    chk({tag, ".send"}, W'(out_send), W'(e_send));
    chk({tag, ".data"}, out_data, e_data);
    chk({tag, ".full"}, W'(vc_full), W'({m_valid[1], m_valid[0]}));
  endtask

  initial begin
    //          pol rq        data    rdy g         full  send dout
    tbl[0]  = '{0, 5'b00100, 64'hA5, 1, 5'b00100, 2'b01, 0, 64'h0};
    tbl[1]  = '{1, 5'b00000, 64'h0,  1, 5'b00000, 2'b00, 1, 64'hA5};
    tbl[2]  = '{0, 5'b00000, 64'h0,  1, 5'b00000, 2'b00, 0, 64'h0};
    tbl[3]  = '{0, 5'b10000, 64'h0,  1, 5'b10000, 2'b01, 0, 64'h0};
    tbl[4]  = '{1, 5'b00000, 64'h0,  1, 5'b00000, 2'b00, 1, 64'h0};
    tbl[5]  = '{0, 5'b00001, 64'h11, 0, 5'b00001, 2'b01, 0, 64'h0};
    tbl[6]  = '{1, 5'b00001, 64'h22, 0, 5'b00001, 2'b11, 0, 64'h0};
    tbl[7]  = '{0, 5'b00001, 64'h99, 0, 5'b00000, 2'b11, 0, 64'h0};
    tbl[8]  = '{1, 5'b00001, 64'h99, 0, 5'b00000, 2'b11, 0, 64'h0};
    tbl[9]  = '{0, 5'b00000, 64'h0,  1, 5'b00000, 2'b01, 1, 64'h22};
    tbl[10] = '{1, 5'b00001, 64'h33, 1, 5'b00001, 2'b10, 1, 64'h11};
    tbl[11] = '{0, 5'b00000, 64'h0,  0, 5'b00000, 2'b10, 0, 64'h0};
    tbl[12] = '{0, 5'b00100, 64'h44, 1, 5'b00100, 2'b01, 1, 64'h33};
    tbl[13] = '{1, 5'b00000, 64'h0,  1, 5'b00000, 2'b00, 1, 64'h44};

    model_reset();

    // Reset state, with requests present to prove grant is masked.
    req = '1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.grant", W'(grant), '0);
    chk("reset.send", W'(out_send), '0);
    chk("reset.data", out_data, '0);
    chk("reset.full", W'(vc_full), '0);
    reset = 1'b0;
    req   = '0;

    // Directed vectors: single flit, zero flit, backpressure, simultaneous fill/drain.
    for (int r = 0; r < 14; r++) begin
      logic [N-1:0] g;
      polarity  = tbl[r].pol;
      req       = tbl[r].rq;
      req_data  = {N{tbl[r].data}};
      out_ready = tbl[r].rdy;
      #1;
      chk($sformatf("vec%0d.grant", r), W'(grant), W'(tbl[r].g));
      g = model_grant();
      model_edge(g);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.full", r), W'(vc_full), W'(tbl[r].full));
      chk($sformatf("vec%0d.send", r), W'(out_send), W'(tbl[r].send));
      chk($sformatf("vec%0d.data", r), out_data, tbl[r].dout);
    end

    // Reset mid-traffic while a flit is being sent.
    req = '1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 64'h1000 + 64'(i);
    polarity = 1'b0; out_ready = 1'b0; cycle("mid.fill0");
    polarity = 1'b1;                   cycle("mid.fill1");
    polarity = 1'b0; out_ready = 1'b1; cycle("mid.drain");
    reset = 1'b1;
    #1;
    chk("mid.rst.send", W'(out_send), '0);
    chk("mid.rst.data", out_data, '0);
    chk("mid.rst.grant", W'(grant), '0);
    chk("mid.rst.full", W'(vc_full), '0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 5'b01000;
    #1;
    chk("mid.req3", W'(grant), W'(5'b01000));

    // Round-robin under full request load with toggling polarity.
    req = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [N-1:0] want;
      polarity = k[0];
      #1;
      want = '0;
      want[(k / 2) % N] = 1'b1;
      chk($sformatf("rr%0d", k), W'(grant), W'(want));
      cycle($sformatf("rr%0d", k));
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) polarity = ~polarity;
      req       = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req_data[i*W +: W] = '0;
        else req_data[i*W +: W] = {$urandom, $urandom};
      end
      cycle($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
